// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the encryption sequencer.
// Contents: round count and Rcon seed, FSM state type, S-box table,
// and the byte/word/state transforms used by the round and key datapaths.
// State layout: byte i of a 128-bit block sits at [127-8i -: 8], column-major
// (byte i is row i%4, column i/4).
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {IDLE, RUN} fsm_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/SubByte.sv
// SubByte: applies the AES S-box to all 16 bytes of a 128-bit state.
// Ports: data_in  [127:0] state before substitution
//        data_out [127:0] state after substitution
module SubByte
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_out[8*i +: 8] = sbox(data_in[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, purely combinational.
// Ports: key      [127:0] current round key (w0..w3, w0 in the MSBs)
//        rcon     [7:0]   round constant for this step
//        next_key [127:0] following round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rw, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rw = rot_word(w3);
  assign t  = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])}
              ^ {rcon, 24'h0};

  // Each new word chains off the previously produced new word.
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl: iterative AES-128 encryption, one round per clock.
// Ports: clk, reset (async, active-high)
//        start          request; accepted only while idle
//        data_in, key_in 128-bit plaintext and cipher key, sampled with start
//        busy           block in flight (10 cycles)
//        done           one-cycle pulse when data_out updates
//        data_out       ciphertext, held until the next completed block
//        round          current round index 0..10
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out,
  output logic [3:0]   round
);

  fsm_state_e   fsm_q, fsm_d;
  logic [127:0] state_r, rkey_r, nkey;
  logic [127:0] sub_out, sr_out, mc_out, round_out;
  logic [7:0]   rcon_r;
  logic         accept, advance, last_round;

  SubByte u_sub_byte (
    .data_in  (state_r),
    .data_out (sub_out)
  );

  aes_key_step u_key_step (
    .key      (rkey_r),
    .rcon     (rcon_r),
    .next_key (nkey)
  );

  assign sr_out     = shift_rows(sub_out);
  assign mc_out     = mix_columns(sr_out);
  assign last_round = (round == 4'(NR));
  // The final round skips MixColumns.
  assign round_out  = (last_round ? sr_out : mc_out) ^ nkey;

  // NOTE: sequential state is updated with <= so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    fsm_d   = fsm_q;
    accept  = 1'b0;
    advance = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          fsm_d  = RUN;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (last_round) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so an abandoned block leaves
  // no key or ciphertext material behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= '0;
      rkey_r   <= '0;
      rcon_r   <= RCON_INIT;
      round    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state_r <= data_in ^ key_in;
        rkey_r  <= key_in;
        rcon_r  <= RCON_INIT;
        round   <= 4'd1;
        busy    <= 1'b1;
      end else if (advance) begin
        state_r <= round_out;
        rkey_r  <= nkey;
        rcon_r  <= xtime(rcon_r);
        if (last_round) begin
          data_out <= round_out;
          done     <= 1'b1;
          busy     <= 1'b0;
          round    <= '0;
        end else begin
          round <= round + 4'd1;
        end
      end
    end
  end

endmodule
